// File: rtl/boost_batch_scheduler.sv
// -----------------------------------------------------------------------------
// boost_batch_scheduler
//
// Purpose: feeds a queue of SNP batch descriptors to the Boost epistasis
// engine one at a time. For each batch it launches the engine, waits for it
// to finish, drains the engine result FIFO into a ready/valid pair stream
// (each pair tagged with its batch id), then clears the engine's done flag.
// Batch and pair counters are kept for the host.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   desc_valid/desc_ready, desc_*    descriptor push (snp count, case/ctrl len)
//   bt_ready, bt_done                engine idle / batch finished
//   bt_snp_pair_num, bt_snp_pair_out engine FIFO level and read data
//   bt_start, bt_clear_done          one-cycle engine handshake pulses
//   bt_snp_num, bt_case_length,
//   bt_ctrl_length                   parameters of the running batch
//   bt_snp_pair_rd_en                engine FIFO pop
//   pair_valid/pair_ready, pair_data,
//   pair_batch_id, pair_last         output pair stream
//   busy, batch_count, total_pairs   status for the host
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module boost_batch_scheduler #(
  parameter int PE_WIDTH          = 16,
  parameter int BLOCK_WIDTH       = 16,
  parameter int QUEUE_DEPTH_WIDTH = 2,
  parameter int ID_WIDTH          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [PE_WIDTH-1:0]      desc_snp_num,
  input  logic [BLOCK_WIDTH-1:0]   desc_case_length,
  input  logic [BLOCK_WIDTH-1:0]   desc_ctrl_length,
  input  logic                     bt_ready,
  input  logic                     bt_done,
  input  logic [PE_WIDTH-1:0]      bt_snp_pair_num,
  input  logic [2*PE_WIDTH-1:0]    bt_snp_pair_out,
  output logic                     bt_start,
  output logic                     bt_clear_done,
  output logic [PE_WIDTH-1:0]      bt_snp_num,
  output logic [BLOCK_WIDTH-1:0]   bt_case_length,
  output logic [BLOCK_WIDTH-1:0]   bt_ctrl_length,
  output logic                     bt_snp_pair_rd_en,
  output logic                     pair_valid,
  input  logic                     pair_ready,
  output logic [2*PE_WIDTH-1:0]    pair_data,
  output logic [ID_WIDTH-1:0]      pair_batch_id,
  output logic                     pair_last,
  output logic                     busy,
  output logic [31:0]              batch_count,
  output logic [31:0]              total_pairs
);

  localparam int QUEUE_DEPTH = 1 << QUEUE_DEPTH_WIDTH;
  localparam int DESC_W      = PE_WIDTH + 2 * BLOCK_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_DRAIN_REQ,
    S_DRAIN_CAP, S_DRAIN_HOLD, S_CLEAR, S_WAIT_READY
  } state_t;

  state_t state_q, state_d;

  // Descriptor queue
  logic [DESC_W-1:0]            queue_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [QUEUE_DEPTH_WIDTH:0]   count_q;
  logic                         push, pop;

  // Batch datapath
  logic [PE_WIDTH-1:0]    snp_num_q;
  logic [BLOCK_WIDTH-1:0] case_len_q, ctrl_len_q;
  logic [PE_WIDTH-1:0]    remaining_q;
  logic                   pair_valid_q, pair_last_q;
  logic [2*PE_WIDTH-1:0]  pair_data_q;
  logic [ID_WIDTH-1:0]    batch_id_q;
  logic [31:0]            batch_count_q, total_pairs_q;

  // Readiness depends on the registered count only, so a pop in the same
  // cycle never lets a push into a full queue.
  assign desc_ready = (count_q < (QUEUE_DEPTH_WIDTH+1)'(QUEUE_DEPTH));
  assign push       = desc_valid && desc_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0) && bt_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr_q] <= {desc_snp_num, desc_case_length, desc_ctrl_length};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (pop) state_d = S_LAUNCH;
      S_LAUNCH:     state_d = S_RUN;
      S_RUN:        if (bt_done) state_d = (bt_snp_pair_num == '0) ? S_CLEAR : S_DRAIN_REQ;
      S_DRAIN_REQ:  state_d = S_DRAIN_CAP;
      S_DRAIN_CAP:  state_d = S_DRAIN_HOLD;
      // remaining_q is at least 1 here; more than 1 means pairs remain
      // after this handshake.
      S_DRAIN_HOLD: if (pair_valid_q && pair_ready)
                      state_d = (remaining_q > PE_WIDTH'(1)) ? S_DRAIN_REQ : S_CLEAR;
      S_CLEAR:      state_d = S_WAIT_READY;
      S_WAIT_READY: if (bt_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bt_start          = 1'b0;
    bt_clear_done     = 1'b0;
    bt_snp_pair_rd_en = 1'b0;
    unique case (state_q)
      S_LAUNCH:    bt_start          = 1'b1;
      S_DRAIN_REQ: bt_snp_pair_rd_en = 1'b1;
      S_CLEAR:     bt_clear_done     = 1'b1;
      default:     ;
    endcase
    busy = (state_q != S_IDLE) || (count_q != '0);
  end

  // Queue pointers, batch parameters, drain datapath and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      snp_num_q     <= '0;
      case_len_q    <= '0;
      ctrl_len_q    <= '0;
      remaining_q   <= '0;
      pair_valid_q  <= 1'b0;
      pair_last_q   <= 1'b0;
      pair_data_q   <= '0;
      batch_id_q    <= '0;
      batch_count_q <= '0;
      total_pairs_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + QUEUE_DEPTH_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + QUEUE_DEPTH_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (QUEUE_DEPTH_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (QUEUE_DEPTH_WIDTH+1)'(1);
        default: ;
      endcase

      if (pop) begin
        {snp_num_q, case_len_q, ctrl_len_q} <= queue_mem[rd_ptr_q];
      end

      unique case (state_q)
        S_RUN: begin
          if (bt_done) remaining_q <= bt_snp_pair_num;
        end
        S_DRAIN_CAP: begin
          // Engine read data is valid the cycle after the pop.
          pair_data_q  <= bt_snp_pair_out;
          pair_valid_q <= 1'b1;
          pair_last_q  <= (remaining_q == PE_WIDTH'(1));
        end
        S_DRAIN_HOLD: begin
          if (pair_valid_q && pair_ready) begin
            pair_valid_q  <= 1'b0;
            remaining_q   <= remaining_q - PE_WIDTH'(1);
            total_pairs_q <= total_pairs_q + 32'd1;
          end
        end
        S_CLEAR: begin
          batch_count_q <= batch_count_q + 32'd1;
          batch_id_q    <= batch_id_q + ID_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bt_snp_num     = snp_num_q;
  assign bt_case_length = case_len_q;
  assign bt_ctrl_length = ctrl_len_q;
  assign pair_valid     = pair_valid_q;
  assign pair_data      = pair_data_q;
  assign pair_last      = pair_last_q;
  assign pair_batch_id  = batch_id_q;
  assign batch_count    = batch_count_q;
  assign total_pairs    = total_pairs_q;

endmodule

// File: tb/tb_boost_batch_scheduler.sv
`timescale 1ns/1ps

module tb_boost_batch_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus (both instances see identical inputs)
  logic        desc_valid;
  logic [15:0] desc_snp_num, desc_case_length, desc_ctrl_length;
  logic        bt_ready, bt_done;
  logic [15:0] bt_snp_pair_num;
  logic [31:0] bt_snp_pair_out;
  logic        pair_ready;

  // Main instance (ID_WIDTH = 8)
  logic        desc_ready, bt_start, bt_clear_done, bt_snp_pair_rd_en;
  logic [15:0] bt_snp_num, bt_case_length, bt_ctrl_length;
  logic        pair_valid, pair_last, busy;
  logic [31:0] pair_data, batch_count, total_pairs;
  logic [7:0]  pair_batch_id;

  // Narrow-id instance (ID_WIDTH = 2)
  logic        desc_ready_w2, bt_start_w2, bt_clear_done_w2, bt_snp_pair_rd_en_w2;
  logic [15:0] bt_snp_num_w2, bt_case_length_w2, bt_ctrl_length_w2;
  logic        pair_valid_w2, pair_last_w2, busy_w2;
  logic [31:0] pair_data_w2, batch_count_w2, total_pairs_w2;
  logic [1:0]  pair_batch_id_w2;

  boost_batch_scheduler #(.ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_snp_num(desc_snp_num), .desc_case_length(desc_case_length),
    .desc_ctrl_length(desc_ctrl_length),
    .bt_ready(bt_ready), .bt_done(bt_done),
    .bt_snp_pair_num(bt_snp_pair_num), .bt_snp_pair_out(bt_snp_pair_out),
    .bt_start(bt_start), .bt_clear_done(bt_clear_done),
    .bt_snp_num(bt_snp_num), .bt_case_length(bt_case_length),
    .bt_ctrl_length(bt_ctrl_length), .bt_snp_pair_rd_en(bt_snp_pair_rd_en),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_data(pair_data),
    .pair_batch_id(pair_batch_id), .pair_last(pair_last),
    .busy(busy), .batch_count(batch_count), .total_pairs(total_pairs)
  );

  boost_batch_scheduler #(.ID_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready_w2),
    .desc_snp_num(desc_snp_num), .desc_case_length(desc_case_length),
    .desc_ctrl_length(desc_ctrl_length),
    .bt_ready(bt_ready), .bt_done(bt_done),
    .bt_snp_pair_num(bt_snp_pair_num), .bt_snp_pair_out(bt_snp_pair_out),
    .bt_start(bt_start_w2), .bt_clear_done(bt_clear_done_w2),
    .bt_snp_num(bt_snp_num_w2), .bt_case_length(bt_case_length_w2),
    .bt_ctrl_length(bt_ctrl_length_w2), .bt_snp_pair_rd_en(bt_snp_pair_rd_en_w2),
    .pair_valid(pair_valid_w2), .pair_ready(pair_ready), .pair_data(pair_data_w2),
    .pair_batch_id(pair_batch_id_w2), .pair_last(pair_last_w2),
    .busy(busy_w2), .batch_count(batch_count_w2), .total_pairs(total_pairs_w2)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] exp_desc_q[$];
  int          plan_cnt[$];
  logic [31:0] eng_src[$];
  logic [7:0]  exp_id;

  // ----------------------------------------------------------- engine model
  logic        eng_busy, eng_zero, hold_off;
  logic [31:0] eng_fifo[$];
  int          eng_timer, done_delay, n_load;

  assign bt_ready = !eng_busy && !hold_off;

  always @(posedge clk) begin
    if (rst) begin
      eng_busy        <= 1'b0;
      eng_zero        <= 1'b0;
      bt_done         <= 1'b0;
      bt_snp_pair_out <= '0;
      bt_snp_pair_num <= '0;
      eng_fifo.delete();
    end else begin
      if (bt_start) begin
        n_load = (plan_cnt.size() != 0) ? plan_cnt.pop_front() : 0;
        for (int i = 0; i < n_load; i++)
          eng_fifo.push_back((eng_src.size() != 0) ? eng_src.pop_front() : 32'hDEAD_0000);
        eng_zero  <= (n_load == 0);
        eng_busy  <= 1'b1;
        eng_timer <= done_delay;
      end else if (eng_busy && !bt_done && !bt_clear_done) begin
        if (eng_timer == 0) bt_done <= 1'b1;
        else eng_timer <= eng_timer - 1;
      end
      if (bt_clear_done) begin
        bt_done  <= 1'b0;
        eng_busy <= 1'b0;
      end
      if (bt_snp_pair_rd_en && eng_fifo.size() != 0)
        bt_snp_pair_out <= eng_fifo.pop_front();
      bt_snp_pair_num <= 16'(eng_fifo.size());
    end
  end

  // ----------------------------------------------------------------- monitor
  exp_t        e;
  logic [47:0] d_exp;
  logic        prev_start, done_prev, exp_clr, exp_clr_n, hold_act, hold_last;
  logic [31:0] hold_data;
  logic [7:0]  hold_id;
  int          hs_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      done_prev  = 1'b0;
      exp_clr    = 1'b0;
      hold_act   = 1'b0;
    end else begin
      if (bt_start) begin
        check("start_pulse_single", prev_start, 0);
        if (exp_desc_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          d_exp = exp_desc_q.pop_front();
          check("bt_snp_num", bt_snp_num, d_exp[47:32]);
          check("bt_case_length", bt_case_length, d_exp[31:16]);
          check("bt_ctrl_length", bt_ctrl_length, d_exp[15:0]);
        end
      end
      prev_start = bt_start;

      if (bt_snp_pair_rd_en) begin
        check("rd_en_fifo_nonempty", eng_fifo.size() != 0, 1);
        check("rd_en_while_valid", pair_valid, 0);
      end

      if (hold_act) begin
        check("hold_valid", pair_valid, 1);
        check("hold_data", pair_data, hold_data);
        check("hold_last", pair_last, hold_last);
        check("hold_id", pair_batch_id, hold_id);
      end
      hold_act  = pair_valid && !pair_ready;
      hold_data = pair_data;
      hold_last = pair_last;
      hold_id   = pair_batch_id;

      if (pair_valid && pair_ready) begin
        if (exp_q.size() == 0) check("unexpected_pair", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pair_data", pair_data, e.data);
          check("pair_batch_id", pair_batch_id, e.id);
          check("pair_batch_id_w2", pair_batch_id_w2, 64'(e.id[1:0]));
          check("pair_last", pair_last, e.last);
        end
        $display("pair id=%0d id_w2=%0d data=%08h last=%0b",
                 pair_batch_id, pair_batch_id_w2, pair_data, pair_last);
        hs_cnt++;
      end

      if (exp_clr || bt_clear_done) check("clear_done_timing", bt_clear_done, exp_clr);
      exp_clr_n = 1'b0;
      if (pair_valid && pair_ready && pair_last) exp_clr_n = 1'b1;
      if (bt_done && !done_prev && eng_zero)      exp_clr_n = 1'b1;
      done_prev = bt_done;
      exp_clr   = exp_clr_n;
    end
  end

  // ----------------------------------------------------------------- helpers
  task automatic plan_batch(input logic [15:0] snp, input logic [15:0] cl,
                            input logic [15:0] tl, input int cnt,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2);
    logic [31:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    exp_desc_q.push_back({snp, cl, tl});
    plan_cnt.push_back(cnt);
    for (int i = 0; i < cnt; i++) begin
      eng_src.push_back(d[i]);
      exp_q.push_back('{data: d[i], id: exp_id, last: (i == cnt - 1)});
    end
    exp_id = exp_id + 8'd1;
  endtask

  task automatic push_desc(input logic [15:0] snp, input logic [15:0] cl, input logic [15:0] tl);
    int w;
    desc_valid = 1'b1;
    desc_snp_num = snp; desc_case_length = cl; desc_ctrl_length = tl;
    w = 0;
    while (!desc_ready && w < 300) begin @(posedge clk); #1; w++; end
    check("push_accept", desc_ready, 1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < budget) begin @(posedge clk); #1; w++; end
    check(tag, (exp_q.size() == 0) && !busy, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    desc_valid = 1'b0;
    exp_q.delete(); exp_desc_q.delete(); plan_cnt.delete(); eng_src.delete();
    exp_id = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_desc_ready"}, {desc_ready, desc_ready_w2}, 2'b11);
    check({tag, "_pulses"}, {bt_start, bt_clear_done, bt_snp_pair_rd_en,
                             bt_start_w2, bt_clear_done_w2, bt_snp_pair_rd_en_w2}, 0);
    check({tag, "_params"}, {bt_snp_num, bt_case_length, bt_ctrl_length}, 0);
    check({tag, "_params_w2"}, {bt_snp_num_w2, bt_case_length_w2, bt_ctrl_length_w2}, 0);
    check({tag, "_pair"}, {pair_valid, pair_last, pair_batch_id, pair_data}, 0);
    check({tag, "_pair_w2"}, {pair_valid_w2, pair_last_w2, pair_batch_id_w2, pair_data_w2}, 0);
    check({tag, "_busy"}, {busy, busy_w2}, 0);
    check({tag, "_counts"}, {batch_count, total_pairs}, 0);
    check({tag, "_counts_w2"}, {batch_count_w2, total_pairs_w2}, 0);
  endtask

  task automatic check_counts(input string tag, input logic [31:0] bc, input logic [31:0] tp);
    check({tag, "_batch_count"}, batch_count, bc);
    check({tag, "_total_pairs"}, total_pairs, tp);
    check({tag, "_batch_count_w2"}, batch_count_w2, bc);
    check({tag, "_total_pairs_w2"}, total_pairs_w2, tp);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int w, hs0;
    rst = 1'b1; desc_valid = 1'b0; pair_ready = 1'b1; hold_off = 1'b0;
    desc_snp_num = '0; desc_case_length = '0; desc_ctrl_length = '0;
    done_delay = 3; exp_id = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_reset_outs("reset");

    // Single batch with launch-latency check
    plan_batch(16'd8, 16'd100, 16'd120, 3, 32'h0001_0002, 32'h0003_0005, 32'h0006_0007);
    desc_valid = 1'b1;
    desc_snp_num = 16'd8; desc_case_length = 16'd100; desc_ctrl_length = 16'd120;
    check("t1_desc_ready", desc_ready, 1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    check("lat_start_t1", bt_start, 0);
    check("lat_busy_t1", busy, 1);
    @(posedge clk); #1;
    check("lat_start_t2", bt_start, 1);
    wait_idle("t1_done", 200);
    check_counts("t1", 32'd1, 32'd3);

    // Zero-result batch
    done_delay = 2;
    plan_batch(16'd4, 16'd10, 16'd11, 0, 32'h0, 32'h0, 32'h0);
    push_desc(16'd4, 16'd10, 16'd11);
    wait_idle("t2_done", 200);
    check_counts("t2", 32'd2, 32'd3);

    // Backpressure for 10 cycles on the first pair
    done_delay = 1;
    pair_ready = 1'b0;
    plan_batch(16'd9, 16'd20, 16'd21, 3, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    push_desc(16'd9, 16'd20, 16'd21);
    w = 0;
    while (!pair_valid && w < 200) begin @(posedge clk); #1; w++; end
    check("t3_valid_seen", pair_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t3_valid_after_stall", pair_valid, 1);
    pair_ready = 1'b1;
    wait_idle("t3_done", 200);
    check_counts("t3", 32'd3, 32'd6);

    // Queue full with engine held busy; ids 0..4 (0,1,2,3,0 on the narrow instance)
    do_reset();
    check_reset_outs("reset2");
    hold_off = 1'b1;
    for (int i = 0; i < 5; i++)
      plan_batch(16'(10 + i), 16'(30 + i), 16'(40 + i), 1, 32'hA000_0000 + 32'(i), 32'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      push_desc(16'(10 + i), 16'(30 + i), 16'(40 + i));
    check("q_full_ready", desc_ready, 0);
    desc_valid = 1'b1;
    desc_snp_num = 16'd14; desc_case_length = 16'd34; desc_ctrl_length = 16'd44;
    repeat (3) @(posedge clk);
    #1;
    check("q_full_ready_held", desc_ready, 0);
    check("q_full_busy", busy, 1);
    hold_off = 1'b0;
    push_desc(16'd14, 16'd34, 16'd44);
    wait_idle("t4_done", 600);
    check_counts("t4", 32'd5, 32'd5);

    // Reset in DRAIN_HOLD with 2 pairs remaining, another descriptor queued
    plan_batch(16'd7, 16'd50, 16'd51, 3, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
    plan_batch(16'd6, 16'd52, 16'd53, 1, 32'hC000_0009, 32'h0, 32'h0);
    push_desc(16'd7, 16'd50, 16'd51);
    push_desc(16'd6, 16'd52, 16'd53);
    hs0 = hs_cnt;
    w = 0;
    while (hs_cnt == hs0 && w < 200) begin @(posedge clk); #1; w++; end
    pair_ready = 1'b0;
    check("t5_first_pair", hs_cnt - hs0, 1);
    w = 0;
    while (!pair_valid && w < 50) begin @(posedge clk); #1; w++; end
    check("t5_second_valid", pair_valid, 1);
    do_reset();
    pair_ready = 1'b1;
    check_reset_outs("mid_reset");

    // Fresh batch after reset starts again at id 0
    plan_batch(16'd5, 16'd60, 16'd61, 1, 32'hBEEF_0001, 32'h0, 32'h0);
    push_desc(16'd5, 16'd60, 16'd61);
    wait_idle("t5_done", 200);
    check_counts("t5", 32'd1, 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
